// File: rtl/soc_pkg.sv
// soc_pkg: shared definitions for the on-chip Wishbone bus controller.
//   - address map: internal window at addr[31:16]==INTERNAL_HI, bit SEL_BIT
//     chooses RAM (1) or bootrom (0)
//   - exception cause codes, controller state and slave-select encodings
//   - wb_req_t bundles the master request, decode() maps an address to a slave
package soc_pkg;

  localparam logic [15:0] INTERNAL_HI = 16'hb000;
  localparam int          SEL_BIT     = 15;

  typedef enum logic [1:0] {
    CAUSE_NONE     = 2'd0,
    CAUSE_UNMAPPED = 2'd1,
    CAUSE_ROMWR    = 2'd2,
    CAUSE_TIMEOUT  = 2'd3
  } cause_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ERR  = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_ROM  = 2'd1,
    SEL_RAM  = 2'd2
  } sel_e;

  typedef struct packed {
    logic        cyc;
    logic        stb;
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } wb_req_t;

  // SEL_NONE here means the address falls outside every mapped slave.
  function automatic sel_e decode(input logic [31:0] addr);
    if (addr[31:16] != INTERNAL_HI) return SEL_NONE;
    return addr[SEL_BIT] ? SEL_RAM : SEL_ROM;
  endfunction

endpackage

// File: rtl/wb_timeout_cnt.sv
// wb_timeout_cnt: counts cycles spent waiting for a slave ack.
//   clk, reset  : clock, async active-low reset
//   clr_i       : synchronous clear (priority over en_i)
//   en_i        : count one waiting cycle
//   expired_o   : the current waiting cycle is the TIMEOUT-th one
module wb_timeout_cnt #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (en_i) cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  // cnt_q holds the number of waiting cycles already completed, so the
  // TIMEOUT-th waiting cycle is the one where cnt_q == TIMEOUT-1.
  assign expired_o = en_i && (cnt_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/wb_bus_ctrl.sv
// wb_bus_ctrl: single-master pipelined Wishbone controller for bootrom + RAM.
//   Master side : i_wb_cyc/stb/we/addr/data in; o_wb_data/stall/ack/err out
//   CPU         : o_exception pulse with o_cause (sticky until next error)
//   Bootrom     : o_rom_stb, o_rom_addr; i_rom_data/stall/ack (read-only)
//   RAM         : o_ram_stb/we/addr/data; i_ram_data/stall/ack
// One transaction outstanding at a time. Strobes and stall are combinational
// from the IDLE state; ack/err/exception/cause/read data are registered.
module wb_bus_ctrl
  import soc_pkg::*;
#(
  parameter int ROM_AW  = 7,
  parameter int RAM_AW  = 7,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_wb_cyc,
  input  logic              i_wb_stb,
  input  logic              i_wb_we,
  input  logic [31:0]       i_wb_addr,
  input  logic [31:0]       i_wb_data,
  output logic [31:0]       o_wb_data,
  output logic              o_wb_stall,
  output logic              o_wb_ack,
  output logic              o_wb_err,
  output logic              o_exception,
  output logic [1:0]        o_cause,
  output logic              o_rom_stb,
  output logic [ROM_AW-1:0] o_rom_addr,
  input  logic [31:0]       i_rom_data,
  input  logic              i_rom_stall,
  input  logic              i_rom_ack,
  output logic              o_ram_stb,
  output logic              o_ram_we,
  output logic [RAM_AW-1:0] o_ram_addr,
  output logic [31:0]       o_ram_data,
  input  logic [31:0]       i_ram_data,
  input  logic              i_ram_stall,
  input  logic              i_ram_ack
);

  wb_req_t req;
  assign req = '{cyc: i_wb_cyc, stb: i_wb_stb, we: i_wb_we,
                 addr: i_wb_addr, data: i_wb_data};

  state_e      state_q;
  sel_e        sel_q;
  cause_e      cause_q;
  logic        ack_q, err_q, exc_q;
  logic [31:0] rdata_q;

  sel_e        dsel;
  logic        req_v, rom_stb, ram_stb, accept, bad_req;
  logic        sel_ack, expired;
  logic [31:0] sel_data;

  assign dsel  = decode(req.addr);
  assign req_v = req.cyc && req.stb && (state_q == ST_IDLE);

  always_comb begin
    rom_stb    = 1'b0;
    ram_stb    = 1'b0;
    o_wb_stall = 1'b1;
    if (state_q == ST_IDLE) begin
      // Bootrom writes never reach the slave; they turn into an error instead.
      rom_stb    = req_v && (dsel == SEL_ROM) && !req.we;
      ram_stb    = req_v && (dsel == SEL_RAM);
      o_wb_stall = rom_stb ? i_rom_stall :
                   ram_stb ? i_ram_stall : 1'b0;
    end
  end

  assign accept  = (rom_stb && !i_rom_stall) || (ram_stb && !i_ram_stall);
  assign bad_req = req_v && ((dsel == SEL_NONE) || ((dsel == SEL_ROM) && req.we));

  // Only the slave we are waiting on may complete the transaction.
  assign sel_ack  = ((sel_q == SEL_ROM) && i_rom_ack) ||
                    ((sel_q == SEL_RAM) && i_ram_ack);
  assign sel_data = (sel_q == SEL_ROM) ? i_rom_data : i_ram_data;

  wb_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_tmo (
    .clk       (clk),
    .reset     (reset),
    .clr_i     (state_q != ST_WAIT),
    .en_i      (state_q == ST_WAIT),
    .expired_o (expired)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      sel_q   <= SEL_NONE;
      cause_q <= CAUSE_NONE;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      exc_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
      exc_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            state_q <= ST_WAIT;
            sel_q   <= rom_stb ? SEL_ROM : SEL_RAM;
          end else if (bad_req) begin
            state_q <= ST_ERR;
            cause_q <= (dsel == SEL_NONE) ? CAUSE_UNMAPPED : CAUSE_ROMWR;
            err_q   <= 1'b1;
            exc_q   <= 1'b1;
          end
        end
        ST_WAIT: begin
          // Abort beats ack, ack beats timeout.
          if (!req.cyc) begin
            state_q <= ST_IDLE;
            sel_q   <= SEL_NONE;
          end else if (sel_ack) begin
            state_q <= ST_IDLE;
            sel_q   <= SEL_NONE;
            ack_q   <= 1'b1;
            rdata_q <= sel_data;
          end else if (expired) begin
            state_q <= ST_ERR;
            sel_q   <= SEL_NONE;
            cause_q <= CAUSE_TIMEOUT;
            err_q   <= 1'b1;
            exc_q   <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign o_wb_ack    = ack_q;
  assign o_wb_err    = err_q;
  assign o_exception = exc_q;
  assign o_cause     = cause_q;
  assign o_wb_data   = rdata_q;

  assign o_rom_stb   = rom_stb;
  assign o_rom_addr  = req.addr[ROM_AW+1:2];
  assign o_ram_stb   = ram_stb;
  assign o_ram_we    = ram_stb && req.we;
  assign o_ram_addr  = req.addr[RAM_AW+1:2];
  assign o_ram_data  = req.data;

endmodule

// File: tb/tb_wb_bus_ctrl.sv
// tb_wb_bus_ctrl: directed stimulus, a transaction-level model of the bus
// (one outstanding request, its age, pending response) checked against the
// DUT every cycle, plus literal expectations taken from the worked examples.
module tb_wb_bus_ctrl;

  localparam int ROM_AW  = 7;
  localparam int RAM_AW  = 7;
  localparam int TIMEOUT = 15;

  logic              clk = 1'b0;
  logic              reset;
  logic              i_wb_cyc, i_wb_stb, i_wb_we;
  logic [31:0]       i_wb_addr, i_wb_data;
  logic [31:0]       o_wb_data;
  logic              o_wb_stall, o_wb_ack, o_wb_err, o_exception;
  logic [1:0]        o_cause;
  logic              o_rom_stb;
  logic [ROM_AW-1:0] o_rom_addr;
  logic [31:0]       i_rom_data;
  logic              i_rom_stall, i_rom_ack;
  logic              o_ram_stb, o_ram_we;
  logic [RAM_AW-1:0] o_ram_addr;
  logic [31:0]       o_ram_data, i_ram_data;
  logic              i_ram_stall, i_ram_ack;

  wb_bus_ctrl #(.ROM_AW(ROM_AW), .RAM_AW(RAM_AW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .i_wb_cyc(i_wb_cyc), .i_wb_stb(i_wb_stb), .i_wb_we(i_wb_we),
    .i_wb_addr(i_wb_addr), .i_wb_data(i_wb_data),
    .o_wb_data(o_wb_data), .o_wb_stall(o_wb_stall), .o_wb_ack(o_wb_ack),
    .o_wb_err(o_wb_err), .o_exception(o_exception), .o_cause(o_cause),
    .o_rom_stb(o_rom_stb), .o_rom_addr(o_rom_addr), .i_rom_data(i_rom_data),
    .i_rom_stall(i_rom_stall), .i_rom_ack(i_rom_ack),
    .o_ram_stb(o_ram_stb), .o_ram_we(o_ram_we), .o_ram_addr(o_ram_addr),
    .o_ram_data(o_ram_data), .i_ram_data(i_ram_data),
    .i_ram_stall(i_ram_stall), .i_ram_ack(i_ram_ack)
  );

  always #5 clk = ~clk;

  int tot = 0;
  int bad = 0;
  logic chk_en = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tot++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  // m_busy: a request is outstanding; m_tgt: 1 bootrom, 2 RAM;
  // m_waited: waiting cycles already spent on it. e_*: what the registered
  // outputs must show in the cycle after the edge.
  logic        m_busy   = 1'b0;
  int          m_tgt    = 0;
  int          m_waited = 0;
  logic        e_ack    = 1'b0;
  logic        e_err    = 1'b0;
  logic [1:0]  e_cause  = 2'd0;
  logic [31:0] e_data   = 32'd0;

  always @(posedge clk or negedge reset) begin : model
    logic        nack, nerr, nbusy;
    logic [1:0]  ncause;
    logic [31:0] ndata;
    int          ntgt, nwait;
    if (!reset) begin
      m_busy <= 1'b0; m_tgt <= 0; m_waited <= 0;
      e_ack <= 1'b0; e_err <= 1'b0; e_cause <= 2'd0; e_data <= 32'd0;
    end else begin
      nack = 1'b0; nerr = 1'b0; nbusy = m_busy; ncause = e_cause;
      ndata = e_data; ntgt = m_tgt; nwait = m_waited + 1;
      if (e_err) begin
        nbusy = 1'b0; // error-report cycle: nothing is taken
      end else if (!m_busy) begin
        if (i_wb_cyc && i_wb_stb) begin
          if (i_wb_addr[31:16] != 16'hb000) begin
            nerr = 1'b1; ncause = 2'd1;
          end else if (!i_wb_addr[15] && i_wb_we) begin
            nerr = 1'b1; ncause = 2'd2;
          end else if (!i_wb_addr[15]) begin
            if (!i_rom_stall) begin nbusy = 1'b1; ntgt = 1; nwait = 0; end
          end else if (!i_ram_stall) begin
            nbusy = 1'b1; ntgt = 2; nwait = 0;
          end
        end
      end else if (!i_wb_cyc) begin
        nbusy = 1'b0;
      end else if ((m_tgt == 1 && i_rom_ack) || (m_tgt == 2 && i_ram_ack)) begin
        nack = 1'b1; nbusy = 1'b0;
        ndata = (m_tgt == 1) ? i_rom_data : i_ram_data;
      end else if (m_waited + 1 == TIMEOUT) begin
        nerr = 1'b1; ncause = 2'd3; nbusy = 1'b0;
      end
      m_busy <= nbusy; m_tgt <= ntgt; m_waited <= nwait;
      e_ack <= nack; e_err <= nerr; e_cause <= ncause; e_data <= ndata;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin : cmp
    logic idle, rq, in_rom, in_ram, x_rom_stb, x_ram_stb, x_stall;
    if (chk_en) begin
      idle      = !m_busy && !e_err;
      rq        = i_wb_cyc && i_wb_stb;
      in_rom    = (i_wb_addr[31:16] == 16'hb000) && !i_wb_addr[15];
      in_ram    = (i_wb_addr[31:16] == 16'hb000) &&  i_wb_addr[15];
      x_rom_stb = idle && rq && in_rom && !i_wb_we;
      x_ram_stb = idle && rq && in_ram;
      x_stall   = !idle ? 1'b1 : x_rom_stb ? i_rom_stall :
                  x_ram_stb ? i_ram_stall : 1'b0;
      check("m_ack",   32'(o_wb_ack),    32'(e_ack));
      check("m_err",   32'(o_wb_err),    32'(e_err));
      check("m_exc",   32'(o_exception), 32'(e_err));
      check("m_cause", 32'(o_cause),     32'(e_cause));
      check("m_data",  o_wb_data,        e_data);
      check("m_stall", 32'(o_wb_stall),  32'(x_stall));
      check("m_romstb",32'(o_rom_stb),   32'(x_rom_stb));
      check("m_ramstb",32'(o_ram_stb),   32'(x_ram_stb));
      check("m_ramwe", 32'(o_ram_we),    32'(x_ram_stb && i_wb_we));
      check("m_romadr",32'(o_rom_addr),  32'(i_wb_addr[ROM_AW+1:2]));
      check("m_ramadr",32'(o_ram_addr),  32'(i_wb_addr[RAM_AW+1:2]));
      check("m_ramdat",o_ram_data,       i_wb_data);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask
  task automatic mid();
    @(negedge clk);
  endtask
  task automatic bus(input logic c, input logic s, input logic w,
                     input logic [31:0] a, input logic [31:0] d);
    i_wb_cyc = c; i_wb_stb = s; i_wb_we = w; i_wb_addr = a; i_wb_data = d;
  endtask

  initial begin
    reset = 1'b1;
    bus(0, 0, 0, 32'h0, 32'h0);
    i_rom_data = 32'h0; i_rom_stall = 1'b0; i_rom_ack = 1'b0;
    i_ram_data = 32'h0; i_ram_stall = 1'b0; i_ram_ack = 1'b0;
    #2 reset = 1'b0;
    #1 chk_en = 1'b1;
    mid();
    check("rst_ack",   32'(o_wb_ack), 32'd0);
    check("rst_err",   32'(o_wb_err), 32'd0);
    check("rst_exc",   32'(o_exception), 32'd0);
    check("rst_cause", 32'(o_cause), 32'd0);
    check("rst_data",  o_wb_data, 32'd0);
    check("rst_stall", 32'(o_wb_stall), 32'd0);
    #2 reset = 1'b1;

    // bootrom read, slave acks one cycle after the strobe
    step(); bus(1, 1, 0, 32'hb000_0010, 32'h0);
    mid();  check("rom_stb", 32'(o_rom_stb), 32'd1);
            check("rom_addr", 32'(o_rom_addr), 32'd4);
            check("rom_stall0", 32'(o_wb_stall), 32'd0);
    step(); i_wb_stb = 0; i_rom_ack = 1; i_rom_data = 32'hdead_beef;
    mid();  check("rom_wait_stall", 32'(o_wb_stall), 32'd1);
    step(); i_rom_ack = 0;
    mid();  check("rom_ack", 32'(o_wb_ack), 32'd1);
            check("rom_data", o_wb_data, 32'hdead_beef);
            check("rom_noerr", 32'(o_wb_err), 32'd0);
    step(); i_wb_cyc = 0;
    mid();  check("rom_ack_once", 32'(o_wb_ack), 32'd0);

    // RAM write stalled for two cycles
    step(); bus(1, 1, 1, 32'hb000_8008, 32'h1234_5678); i_ram_stall = 1;
    mid();  check("ram_stall1", 32'(o_wb_stall), 32'd1);
            check("ram_stb_st", 32'(o_ram_stb), 32'd1);
    step();
    mid();  check("ram_stall2", 32'(o_wb_stall), 32'd1);
    step(); i_ram_stall = 0;
    mid();  check("ram_accept", 32'(o_wb_stall), 32'd0);
            check("ram_we", 32'(o_ram_we), 32'd1);
            check("ram_addr", 32'(o_ram_addr), 32'd2);
            check("ram_wdata", o_ram_data, 32'h1234_5678);
    step(); i_wb_stb = 0; i_ram_ack = 1; i_ram_data = 32'hcafe_0001;
    mid();
    step(); i_ram_ack = 0; bus(0, 0, 0, 32'h0, 32'h0);
    mid();  check("ram_ack", 32'(o_wb_ack), 32'd1);
            check("ram_cause0", 32'(o_cause), 32'd0);
            check("ram_data", o_wb_data, 32'hcafe_0001);

    // unmapped read
    step(); bus(1, 1, 0, 32'hc000_0000, 32'h0);
    mid();  check("um_romstb", 32'(o_rom_stb), 32'd0);
            check("um_ramstb", 32'(o_ram_stb), 32'd0);
            check("um_stall", 32'(o_wb_stall), 32'd0);
    step(); bus(0, 0, 0, 32'h0, 32'h0);
    mid();  check("um_err", 32'(o_wb_err), 32'd1);
            check("um_exc", 32'(o_exception), 32'd1);
            check("um_cause", 32'(o_cause), 32'd1);
    step();
    mid();  check("um_err_once", 32'(o_wb_err), 32'd0);
            check("um_cause_hold", 32'(o_cause), 32'd1);

    // bootrom write
    step(); bus(1, 1, 1, 32'hb000_0000, 32'h5555_aaaa);
    mid();  check("rw_romstb", 32'(o_rom_stb), 32'd0);
    step(); bus(0, 0, 0, 32'h0, 32'h0);
    mid();  check("rw_err", 32'(o_wb_err), 32'd1);
            check("rw_cause", 32'(o_cause), 32'd2);
    step();

    // RAM read never acked: error after TIMEOUT waiting cycles
    step(); bus(1, 1, 0, 32'hb000_8010, 32'h0);
    mid();
    for (int i = 1; i <= TIMEOUT; i++) begin
      step(); i_wb_stb = 0;
      mid();  check("to_waiting", 32'(o_wb_err), 32'd0);
    end
    step();
    mid();  check("to_err", 32'(o_wb_err), 32'd1);
            check("to_cause", 32'(o_cause), 32'd3);
    step(); i_wb_cyc = 0;
    step(); step();
    step(); i_ram_ack = 1; i_ram_data = 32'hbad0_bad0;
    step(); i_ram_ack = 0;
    mid();  check("late_ack", 32'(o_wb_ack), 32'd0);
            check("late_data", o_wb_data, 32'hcafe_0001);

    // ack on the last permitted cycle wins; a bootrom ack meanwhile is stray
    step(); bus(1, 1, 0, 32'hb000_8014, 32'h0);
    mid();
    for (int i = 1; i <= TIMEOUT; i++) begin
      step(); i_wb_stb = 0; i_rom_ack = (i == 5); i_ram_ack = (i == TIMEOUT);
      i_ram_data = 32'h5a5a_0015;
      mid();  check("race_noack", 32'(o_wb_ack), 32'd0);
    end
    step(); i_rom_ack = 0; i_ram_ack = 0; i_wb_cyc = 0;
    mid();  check("race_ack", 32'(o_wb_ack), 32'd1);
            check("race_noerr", 32'(o_wb_err), 32'd0);
            check("race_data", o_wb_data, 32'h5a5a_0015);

    // abort: cyc dropped while waiting, then a stray ack
    step(); bus(1, 1, 0, 32'hb000_0020, 32'h0);
    mid();
    step(); bus(0, 0, 0, 32'h0, 32'h0);
    mid();
    step(); i_rom_ack = 1; i_rom_data = 32'h0bad_0001;
    mid();  check("ab_idle_stall", 32'(o_wb_stall), 32'd0);
    step(); i_rom_ack = 0;
    mid();  check("ab_noack", 32'(o_wb_ack), 32'd0);
            check("ab_noerr", 32'(o_wb_err), 32'd0);

    // reset while waiting on RAM
    step(); bus(1, 1, 0, 32'hb000_8018, 32'h0);
    mid();
    step(); i_wb_stb = 0;
    mid();  check("rw_wait_stall", 32'(o_wb_stall), 32'd1);
    #2 reset = 1'b0;
    #1;     check("mr_ack", 32'(o_wb_ack), 32'd0);
            check("mr_err", 32'(o_wb_err), 32'd0);
            check("mr_exc", 32'(o_exception), 32'd0);
            check("mr_cause", 32'(o_cause), 32'd0);
            check("mr_data", o_wb_data, 32'd0);
            check("mr_stall", 32'(o_wb_stall), 32'd0);
            check("mr_ramstb", 32'(o_ram_stb), 32'd0);
    step(); i_ram_ack = 1; i_ram_data = 32'h7777_7777;
    mid();
    #2 reset = 1'b1;
    step(); i_ram_ack = 0; i_wb_cyc = 0;
    mid();  check("mr_noack", 32'(o_wb_ack), 32'd0);
            check("mr_noerr", 32'(o_wb_err), 32'd0);
    step(); step();
    mid();

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end

endmodule
